multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  FSM that sequences a shared-ALU, shared-memory RV32I subset datapath over several cycles per instruction.
//  Drives mux selects, register/IR/PC write enables and memory request from decoded op/funct fields.
//  Handshakes with a variable-latency unified memory port (mem_req/mem_ready).
//  Sits beside the datapath in top-level; replaces the single-cycle combinational control unit.
// PARAMETERS
//  WAIT_LIMIT   15  max cycles a memory state waits for mem_ready before entering FAULT (1..255)
//  CNT_WIDTH    32  width of instret counter (only used with PERF_CNT_EN)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-low
//  op          in   7   instr[6:0] from instruction register
//  funct3      in   3   instr[14:12]
//  funct7_5    in   1   instr[30]
//  Zero        in   1   ALU equality flag (1 = operands equal)
//  mem_ready   in   1   memory completes current access this cycle
//  mem_req     out  1   memory access request
//  AdrSrc      out  1   0 = PC, 1 = ALUOut as memory address
//  MemWrite    out  1   memory write strobe
//  IRWrite     out  1   load instruction register
//  PCWrite     out  1   load PC
//  RegWrite    out  1   register file write enable
//  ResultSrc   out  2   00 ALUOut, 01 ReadData, 10 ALUResult
//  ALUSrcA     out  2   00 PC, 01 OldPC, 10 RD1
//  ALUSrcB     out  2   00 RD2, 01 ImmExt, 10 const 4
//  ImmSrc      out  2   00 I, 01 S, 10 B, 11 J
//  ALUControl  out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//  state_o     out  4   current state encoding (debug)
//  fault       out  1   sticky: illegal opcode or memory timeout
// BEHAVIOUR
//  - rst low: state=FETCH, wait counter=0, fault=0; all strobes (mem_req excepted) 0, selects 0. Async assert, sync release.
//  - Outputs decoded from state only, except PCWrite = pc_update | (Branch & Zero).
//  - States/transitions:
//    FETCH: mem_req=1, AdrSrc=0; on mem_ready: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, add -> DECODE; else stay.
//    DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (branch target). op: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI,
//      beq->BEQ, jal->JAL, other->FAULT.
//    MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=00(lw)/01(sw) -> MEMREAD (lw) or MEMWRITE (sw).
//    MEMREAD: mem_req=1, AdrSrc=1; on mem_ready -> MEMWB.  MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//    MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held until mem_ready -> FETCH.
//    EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct3/funct7_5 -> ALUWB.
//    EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUControl from funct3 (funct7_5 ignored) -> ALUWB.
//    ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
//    BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1 -> FETCH.
//    JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
//    FAULT: all strobes 0, mem_req=0, fault=1; absorbing until rst.
//  - ALU decode: funct3 000 add (sub if R and funct7_5=1), 010 slt, 110 or, 111 and; other funct3 -> FAULT next.
//  - Wait counter: cleared on entering each memory state, +1 per cycle mem_ready=0; reaching WAIT_LIMIT
//    with mem_ready=0 -> FAULT. mem_ready on the limit cycle completes normally (ready wins).
//  - mem_ready outside memory states ignored. Same-cycle mem_req rise and mem_ready accepted (0-wait memory).
//  - CPI with 0-wait memory: lw 5, sw 4, R/I 4, beq 3, jal 4.
// CONFIGURATION
//  PERF_CNT_EN defined: adds output instret [CNT_WIDTH-1:0], reset 0, +1 on every transition into FETCH
//    from a completing state (MEMWB, MEMWRITE, ALUWB, BEQ); wraps at 2^CNT_WIDTH; frozen in FAULT.
//  PERF_CNT_EN undefined: port and counter absent; no other change.
// TESTING
//  add x1,x2,x3 with mem_ready tied 1 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; 4 cycles.
//  lw with mem_ready delayed 3 cycles in MEMREAD -> mem_req/AdrSrc=1 held 4 cycles; RegWrite 1 cycle later.
//  beq Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both return to FETCH.
//  mem_ready held 0 in FETCH, WAIT_LIMIT=15 -> FAULT after 15 cycles, fault=1, mem_req=0 thereafter.
//  op=7'b1111111 -> FAULT after DECODE; rst low mid-MEMWRITE -> MemWrite=0 immediately, state=FETCH.
//  PERF_CNT_EN: 3 instructions (lw, add, beq) -> instret=3; reset -> 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for a shared-ALU/shared-memory RV32I subset; outputs are decoded from state, with memory handshake and wait timeout.
// Define PERF_CNT_EN to add the instret retired-instruction counter output. state_o: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BEQ=9 JAL=10 FAULT=11.
module multicycle_controller #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_WIDTH  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o,
  output logic       fault
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instret
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255 || CNT_WIDTH < 1) begin : g_bad_param
    $error("multicycle_controller: WAIT_LIMIT must be 1..255 and CNT_WIDTH >= 1");
  end

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_alu_legal;
  logic [2:0] w_alu_ctl;
  logic       w_branch;
  logic       w_pc_update;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  // Ready on the last permitted cycle still completes; only a missing ready faults.
  assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == WAIT_LAST);

  always_comb begin
    w_alu_legal = 1'b1;
    w_alu_ctl   = 3'b000;
    case (funct3)
      3'b000:  w_alu_ctl = ((r_state == S_EXECR) && funct7_5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_ctl = 3'b101;
      3'b110:  w_alu_ctl = 3'b011;
      3'b111:  w_alu_ctl = 3'b010;
      default: w_alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;   else if (w_timeout) w_next = S_FAULT;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FAULT;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;    else if (w_timeout) w_next = S_FAULT;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;    else if (w_timeout) w_next = S_FAULT;
      S_EXECR,
      S_EXECI:    w_next = w_alu_legal ? S_ALUWB : S_FAULT;
      S_ALUWB,
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_mem_state && !mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + 8'd1;
      else                                         r_wait_cnt <= 8'd0;
    end
  end

`ifdef PERF_CNT_EN
  logic w_retire;
  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                     (r_state == S_ALUWB) || (r_state == S_BEQ));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          instret <= '0;
    else if (w_retire) instret <= instret + 1'b1;
  end
`endif

  always_comb begin
    mem_req     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ImmSrc      = 2'b00;
    ALUControl  = 3'b000;
    case (r_state)
      S_FETCH: begin
        mem_req     = 1'b1;
        IRWrite     = mem_ready;
        w_pc_update = mem_ready;
        ALUSrcB     = mem_ready ? 2'b10 : 2'b00;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = 2'b10; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = (op == OP_SW) ? 2'b01 : 2'b00; end
      S_MEMREAD:  begin mem_req = 1'b1; AdrSrc = 1'b1; end
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUControl = w_alu_ctl; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = w_alu_ctl; end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ:      begin ALUSrcA = 2'b10; ALUControl = 3'b001; w_branch = 1'b1; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pc_update = 1'b1; end
      default:    ;
    endcase
  end

  assign PCWrite = w_pc_update | (w_branch & Zero);
  assign state_o = r_state;
  assign fault   = (r_state == S_FAULT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expectations queued as stimulus is applied, popped and compared each cycle.
module tb_multicycle_controller;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMREAD = 4'd3,
                         ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5, ST_EXECR = 4'd6, ST_EXECI = 4'd7,
                         ST_ALUWB = 4'd8, ST_BEQ = 4'd9, ST_JAL = 4'd10, ST_FAULT = 4'd11;
  localparam logic [6:0] MREQ = 7'b1000000, ADR = 7'b0100000, MW = 7'b0010000, IRW = 7'b0001000,
                         PCW = 7'b0000100, RW = 7'b0000010, FLT = 7'b0000001, NONE = 7'b0000000;
  localparam logic [10:0] M_RS = 11'b11000000000, M_A = 11'b00110000000, M_B = 11'b00001100000,
                          M_I = 11'b00000011000, M_ALU = 11'b00000000111;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, Zero, mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
`ifdef PERF_CNT_EN
  logic [31:0] instret;
`endif

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .state_o(state_o), .fault(fault)
`ifdef PERF_CNT_EN
    , .instret(instret)
`endif
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [6:0]  strb;
    logic [10:0] sel;
    logic [10:0] mask;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, step = 0, exp_ret = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [10:0] sel(input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] i, input logic [2:0] alu);
    return {rs, a, b, i, alu};
  endfunction

  task automatic push(input logic [3:0] st, input logic [6:0] strb,
                      input logic [10:0] s = 11'd0, input logic [10:0] m = 11'd0);
    exp_t e;
    e.st = st; e.strb = strb; e.sel = s; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t        e;
    logic [10:0] got_ctl, got_sel;
    #1;
    step++;
    checks++;
    assert (sb.size() > 0) else begin
      errors++; $error("FAIL sb_empty step %0d: got 0 entries expected at least 1", step);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got_ctl = {state_o, mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, fault};
      assert (got_ctl === {e.st, e.strb}) else begin
        errors++; $error("FAIL ctl step %0d: got %03h expected %03h", step, got_ctl, {e.st, e.strb});
      end
      if (e.mask != 11'd0) begin
        checks++;
        got_sel = {ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
        assert ((got_sel & e.mask) === (e.sel & e.mask)) else begin
          errors++; $error("FAIL sel step %0d: got %03h expected %03h (mask %03h)", step, got_sel, e.sel, e.mask);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_ret(input string tag);
`ifdef PERF_CNT_EN
    checks++;
    assert (instret === 32'(exp_ret)) else begin
      errors++; $error("FAIL instret_%s: got %0d expected %0d", tag, instret, exp_ret);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
    push(ST_FETCH, MREQ, 11'd0, M_RS | M_A | M_B | M_I | M_ALU);
    cyc();
    exp_ret = 0;
    chk_ret("reset");
    rst = 1'b1;
  endtask

  task automatic fetch_decode(input int waits);
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0; push(ST_FETCH, MREQ); cyc();
    end
    mem_ready = 1'b1;
    push(ST_FETCH, MREQ | IRW | PCW, sel(2'b00, 2'b00, 2'b10, 2'b00, 3'b000), M_A | M_B | M_ALU); cyc();
    push(ST_DECODE, NONE, sel(2'b00, 2'b01, 2'b01, 2'b10, 3'b000), M_A | M_B | M_I | M_ALU); cyc();
  endtask

  task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [2:0] alu, input int waits);
    op = o; funct3 = f3; funct7_5 = f7;
    fetch_decode(waits);
    if (o == OP_R) push(ST_EXECR, NONE, sel(2'b00, 2'b10, 2'b00, 2'b00, alu), M_A | M_B | M_ALU);
    else           push(ST_EXECI, NONE, sel(2'b00, 2'b10, 2'b01, 2'b00, alu), M_A | M_B | M_I | M_ALU);
    cyc();
    push(ST_ALUWB, RW, 11'd0, M_RS); cyc();
    exp_ret++;
  endtask

  task automatic run_lw(input int waits);
    op = OP_LW; funct3 = 3'b010;
    fetch_decode(0);
    push(ST_MEMADR, NONE, sel(2'b00, 2'b10, 2'b01, 2'b00, 3'b000), M_A | M_B | M_I | M_ALU); cyc();
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0; push(ST_MEMREAD, MREQ | ADR); cyc();
    end
    mem_ready = 1'b1; push(ST_MEMREAD, MREQ | ADR); cyc();
    push(ST_MEMWB, RW, sel(2'b01, 2'b00, 2'b00, 2'b00, 3'b000), M_RS); cyc();
    exp_ret++;
  endtask

  task automatic run_sw(input int waits);
    op = OP_SW; funct3 = 3'b010;
    fetch_decode(0);
    push(ST_MEMADR, NONE, sel(2'b00, 2'b10, 2'b01, 2'b01, 3'b000), M_A | M_B | M_I | M_ALU); cyc();
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0; push(ST_MEMWRITE, MREQ | ADR | MW); cyc();
    end
    mem_ready = 1'b1; push(ST_MEMWRITE, MREQ | ADR | MW); cyc();
    exp_ret++;
  endtask

  task automatic run_beq(input logic z);
    op = OP_BEQ; funct3 = 3'b000; Zero = z;
    fetch_decode(0);
    push(ST_BEQ, z ? PCW : NONE, sel(2'b00, 2'b10, 2'b00, 2'b00, 3'b001), M_RS | M_A | M_B | M_ALU); cyc();
    Zero = 1'b0;
    exp_ret++;
  endtask

  task automatic run_jal();
    op = OP_JAL;
    fetch_decode(0);
    push(ST_JAL, PCW, sel(2'b00, 2'b01, 2'b10, 2'b00, 3'b000), M_RS | M_A | M_B | M_ALU); cyc();
    push(ST_ALUWB, RW, 11'd0, M_RS); cyc();
    exp_ret++;
  endtask

  task automatic expect_fault(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ready = k[0]; push(ST_FAULT, FLT); cyc();
    end
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    run_alu(OP_R, 3'b000, 1'b0, 3'b000, 0);
    run_alu(OP_R, 3'b000, 1'b1, 3'b001, 0);
    run_alu(OP_R, 3'b010, 1'b0, 3'b101, 0);
    run_alu(OP_I, 3'b000, 1'b1, 3'b000, 0);
    run_alu(OP_I, 3'b110, 1'b0, 3'b011, 0);
    run_alu(OP_I, 3'b111, 1'b1, 3'b010, 0);
    run_lw(3);
    run_sw(2);
    run_beq(1'b1);
    run_beq(1'b0);
    run_jal();
    run_alu(OP_R, 3'b000, 1'b0, 3'b000, 14);
    run_alu(OP_R, 3'b110, 1'b0, 3'b011, 14);
    run_lw(14);
    run_sw(14);
    chk_ret("mix");

    op = OP_R; funct3 = 3'b001; funct7_5 = 1'b0;
    fetch_decode(0);
    push(ST_EXECR, NONE); cyc();
    expect_fault(3);
    chk_ret("frozen");

    do_reset();
    run_lw(0);
    run_alu(OP_R, 3'b000, 1'b0, 3'b000, 0);
    run_beq(1'b1);
    chk_ret("three");

    op = 7'b1111111;
    fetch_decode(0);
    expect_fault(3);

    do_reset();
    op = OP_R; funct3 = 3'b000;
    for (int k = 0; k < 15; k++) begin
      mem_ready = 1'b0; push(ST_FETCH, MREQ); cyc();
    end
    expect_fault(4);

    do_reset();
    op = OP_SW;
    fetch_decode(0);
    push(ST_MEMADR, NONE); cyc();
    mem_ready = 1'b0;
    push(ST_MEMWRITE, MREQ | ADR | MW); cyc();
    #2;
    rst = 1'b0;
    push(ST_FETCH, MREQ); cyc();
    rst = 1'b1;
    exp_ret = 0;
    chk_ret("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
